// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: pipeline writeback, long-latency result handshake,
// issue/scoreboard and register-file write port in one bundle.
interface wb_arbiter_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int QUEUE_DEPTH = 4
);
    logic                         wb_valid;
    logic [4:0]                   wb_rd;
    logic [DATA_WIDTH-1:0]        wb_data;
    logic                         lu_valid;
    logic [4:0]                   lu_rd;
    logic [DATA_WIDTH-1:0]        lu_data;
    logic                         lu_ready;
    logic                         issue_valid;
    logic [4:0]                   issue_rd;
    logic [31:0]                  busy_mask;
    logic                         rf_we;
    logic [4:0]                   rf_a3;
    logic [DATA_WIDTH-1:0]        rf_wd3;
    logic [$clog2(QUEUE_DEPTH):0] q_count;

    // Producer side: pipeline, long-latency unit and decode.
    modport master (
        output wb_valid, wb_rd, wb_data,
        output lu_valid, lu_rd, lu_data,
        output issue_valid, issue_rd,
        input  lu_ready, busy_mask, rf_we, rf_a3, rf_wd3, q_count
    );

    // Arbiter side.
    modport slave (
        input  wb_valid, wb_rd, wb_data,
        input  lu_valid, lu_rd, lu_data,
        input  issue_valid, issue_rd,
        output lu_ready, busy_mask, rf_we, rf_a3, rf_wd3, q_count
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: owns the register file write port. The in-order pipeline
// always wins; long-latency results that lose arbitration wait in a FIFO.
// A busy scoreboard tracks registers awaiting long-latency results.
// Optional macro WB_FWD_EN adds operand forwarding of the pending write
// (fwd_a1/fwd_a2, rf_rd1/rf_rd2 -> op1/op2).
module wb_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    wb_arbiter_if.slave           bus
`ifdef WB_FWD_EN
    ,
    input  logic [4:0]            fwd_a1,
    input  logic [4:0]            fwd_a2,
    input  logic [DATA_WIDTH-1:0] rf_rd1,
    input  logic [DATA_WIDTH-1:0] rf_rd2,
    output logic [DATA_WIDTH-1:0] op1,
    output logic [DATA_WIDTH-1:0] op2
`endif
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

    logic [4:0]            q_rd   [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0] q_data [QUEUE_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [31:0]           busy;

    logic                  rf_we_r;
    logic [4:0]            rf_a3_r;
    logic [DATA_WIDTH-1:0] rf_wd3_r;

    logic                  lu_ready_c;
    logic                  sel_wb;
    logic                  sel_q;
    logic                  sel_lu;
    logic                  push;
    logic                  nxt_we;
    logic [4:0]            nxt_a3;
    logic [DATA_WIDTH-1:0] nxt_wd3;
    logic [31:0]           clr_mask;
    logic [31:0]           set_mask;
    logic [31:0]           busy_nxt;

    // Arbitration, FIFO handshake and scoreboard next-state.
    always_comb begin
        lu_ready_c = (count < DEPTH_C);
        sel_wb     = bus.wb_valid && (bus.wb_rd != 5'd0);
        sel_q      = !sel_wb && (count != '0);
        sel_lu     = !sel_wb && (count == '0) && bus.lu_valid && (bus.lu_rd != 5'd0);
        // rd==0 results are consumed but never stored: they would write nothing.
        push       = bus.lu_valid && lu_ready_c && !sel_lu && (bus.lu_rd != 5'd0);
        nxt_we     = sel_wb || sel_q || sel_lu;
        nxt_a3     = rf_a3_r;
        nxt_wd3    = rf_wd3_r;
        clr_mask   = '0;
        set_mask   = '0;
        if (sel_wb) begin
            nxt_a3  = bus.wb_rd;
            nxt_wd3 = bus.wb_data;
        end else if (sel_q) begin
            nxt_a3             = q_rd[rd_ptr];
            nxt_wd3            = q_data[rd_ptr];
            clr_mask[nxt_a3]   = 1'b1;
        end else if (sel_lu) begin
            nxt_a3             = bus.lu_rd;
            nxt_wd3            = bus.lu_data;
            clr_mask[nxt_a3]   = 1'b1;
        end
        if (bus.issue_valid && (bus.issue_rd != 5'd0)) begin
            set_mask[bus.issue_rd] = 1'b1;
        end
        // A set on the same edge as a clear wins; x0 is never busy.
        busy_nxt = ((busy & ~clr_mask) | set_mask) & ~32'd1;
    end

    // Control state: write port, occupancy, pointers and scoreboard.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we_r  <= 1'b0;
            rf_a3_r  <= 5'd0;
            rf_wd3_r <= '0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            busy     <= '0;
        end else begin
            rf_we_r  <= nxt_we;
            rf_a3_r  <= nxt_a3;
            rf_wd3_r <= nxt_wd3;
            busy     <= busy_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (sel_q) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, sel_q})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents are meaningless outside the pointer window.
    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[wr_ptr]   <= bus.lu_rd;
            q_data[wr_ptr] <= bus.lu_data;
        end
    end

`ifndef SYNTHESIS
    // Decode must never issue to a register still awaiting its result.
    always_ff @(posedge clk) begin
        if (!rst && bus.issue_valid && (bus.issue_rd != 5'd0)) begin
            assert (!busy[bus.issue_rd])
            else $error("wb_arbiter: issue to busy register x%0d", bus.issue_rd);
        end
    end
`endif

    assign bus.lu_ready  = lu_ready_c;
    assign bus.busy_mask = busy;
    assign bus.rf_we     = rf_we_r;
    assign bus.rf_a3     = rf_a3_r;
    assign bus.rf_wd3    = rf_wd3_r;
    assign bus.q_count   = count;

`ifdef WB_FWD_EN
    // Bypass the value being written this cycle; the reg file still holds the old one.
    always_comb begin
        op1 = (rf_we_r && (rf_a3_r == fwd_a1) && (fwd_a1 != 5'd0)) ? rf_wd3_r : rf_rd1;
        op2 = (rf_we_r && (rf_a3_r == fwd_a2) && (fwd_a2 != 5'd0)) ? rf_wd3_r : rf_rd2;
    end
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed scenarios plus a randomized run checked
// against a queue-based reference model of the arbitration rules.
module tb_wb_arbiter;
    localparam int DW = 32;
    localparam int QD = 4;

    typedef struct {
        logic [4:0]    rd;
        logic [DW-1:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    wb_arbiter_if #(.DATA_WIDTH(DW), .QUEUE_DEPTH(QD)) bus ();

`ifdef WB_FWD_EN
    logic [4:0]    fwd_a1 = '0;
    logic [4:0]    fwd_a2 = '0;
    logic [DW-1:0] rf_rd1 = '0;
    logic [DW-1:0] rf_rd2 = '0;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    wb_arbiter #(.DATA_WIDTH(DW), .QUEUE_DEPTH(QD)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .fwd_a1(fwd_a1), .fwd_a2(fwd_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .op1(op1), .op2(op2)
    );
`else
    wb_arbiter #(.DATA_WIDTH(DW), .QUEUE_DEPTH(QD)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );
`endif

    always #5 clk = ~clk;

    // Reference model state (what the DUT outputs should be after the edge).
    logic          exp_we = 1'b0;
    logic [4:0]    exp_a3 = '0;
    logic [DW-1:0] exp_wd3 = '0;
    logic [31:0]   exp_busy = '0;
    ent_t          mq[$];
    logic          m_acc = 1'b0;

    task automatic model_step();
        ent_t        e;
        logic [31:0] clr;
        logic [31:0] set;
        bit          ready;
        bit          bypass;
        clr    = '0;
        set    = '0;
        bypass = 0;
        m_acc  = 1'b0;
        if (rst) begin
            exp_we   = 1'b0;
            exp_a3   = '0;
            exp_wd3  = '0;
            exp_busy = '0;
            mq.delete();
            return;
        end
        ready  = (mq.size() < QD);
        m_acc  = bus.lu_valid && ready;
        exp_we = 1'b1;
        if (bus.wb_valid && bus.wb_rd != 0) begin
            exp_a3  = bus.wb_rd;
            exp_wd3 = bus.wb_data;
        end else if (mq.size() != 0) begin
            e       = mq.pop_front();
            exp_a3  = e.rd;
            exp_wd3 = e.data;
            clr[e.rd] = 1'b1;
        end else if (bus.lu_valid && bus.lu_rd != 0) begin
            exp_a3  = bus.lu_rd;
            exp_wd3 = bus.lu_data;
            clr[bus.lu_rd] = 1'b1;
            bypass  = 1;
        end else begin
            exp_we = 1'b0;
        end
        if (m_acc && !bypass && bus.lu_rd != 0) begin
            e.rd   = bus.lu_rd;
            e.data = bus.lu_data;
            mq.push_back(e);
        end
        if (bus.issue_valid && bus.issue_rd != 0) set[bus.issue_rd] = 1'b1;
        exp_busy = ((exp_busy & ~clr) | set) & ~32'd1;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.wb_valid    = 1'b0;
        bus.wb_rd       = '0;
        bus.wb_data     = '0;
        bus.lu_valid    = 1'b0;
        bus.lu_rd       = '0;
        bus.lu_data     = '0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tests++;
        if (bus.rf_we !== 1'b0 || bus.rf_a3 !== 5'd0 || bus.rf_wd3 !== 32'd0) begin
            fails++;
            $display("FAIL reset_rf: we=%0b a3=%0d wd3=%h, want 0/0/0", bus.rf_we, bus.rf_a3, bus.rf_wd3);
        end
        tests++;
        if (bus.busy_mask !== 32'd0 || bus.q_count !== 3'd0) begin
            fails++;
            $display("FAIL reset_state: busy=%h q=%0d, want 0/0", bus.busy_mask, bus.q_count);
        end
        tick();
        tests++;
        if (bus.lu_ready !== 1'b1 || bus.rf_we !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready: lu_ready=%0b rf_we=%0b, want 1/0", bus.lu_ready, bus.rf_we);
        end
    endtask

    task automatic test_wb_basic();
        drive_idle();
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd5;
        bus.wb_data  = 32'hDEADBEEF;
        tick();
        drive_idle();
        tests++;
        if (bus.rf_we !== 1'b1 || bus.rf_a3 !== 5'd5 || bus.rf_wd3 !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL wb_write: we=%0b a3=%0d wd3=%h, want 1/5/deadbeef", bus.rf_we, bus.rf_a3, bus.rf_wd3);
        end
        tick();
        tests++;
        if (bus.rf_we !== 1'b0 || bus.rf_a3 !== 5'd5 || bus.rf_wd3 !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL wb_hold: we=%0b a3=%0d wd3=%h, want 0/5/deadbeef", bus.rf_we, bus.rf_a3, bus.rf_wd3);
        end
    endtask

    task automatic test_x0();
        drive_idle();
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd0;
        bus.wb_data  = 32'h1234;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd0;
        tick();
        drive_idle();
        tests++;
        if (bus.rf_we !== 1'b0 || bus.busy_mask !== 32'd0) begin
            fails++;
            $display("FAIL x0_wb: rf_we=%0b busy=%h, want 0/0", bus.rf_we, bus.busy_mask);
        end
        bus.lu_valid = 1'b1;
        bus.lu_rd    = 5'd0;
        bus.lu_data  = 32'h99;
        tests++;
        if (bus.lu_ready !== 1'b1) begin
            fails++;
            $display("FAIL x0_lu_ready_pre: got %0b want 1", bus.lu_ready);
        end
        tick();
        drive_idle();
        tests++;
        if (bus.rf_we !== 1'b0 || bus.q_count !== 3'd0 || bus.lu_ready !== 1'b1) begin
            fails++;
            $display("FAIL x0_lu: rf_we=%0b q=%0d ready=%0b, want 0/0/1", bus.rf_we, bus.q_count, bus.lu_ready);
        end
        tick();
        tests++;
        if (bus.rf_we !== 1'b0) begin
            fails++;
            $display("FAIL x0_after: rf_we=%0b want 0", bus.rf_we);
        end
    endtask

    task automatic test_scoreboard();
        drive_idle();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd7;
        tick();
        drive_idle();
        tests++;
        if (bus.busy_mask !== 32'h0000_0080) begin
            fails++;
            $display("FAIL sb_set: busy=%h want 00000080", bus.busy_mask);
        end
        tick();
        tests++;
        if (bus.busy_mask !== 32'h0000_0080 || bus.rf_we !== 1'b0) begin
            fails++;
            $display("FAIL sb_hold: busy=%h we=%0b want 00000080/0", bus.busy_mask, bus.rf_we);
        end
        // Pipeline write to a busy register leaves the scoreboard alone.
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd7;
        bus.wb_data  = 32'h77;
        tick();
        drive_idle();
        tests++;
        if (bus.busy_mask !== 32'h0000_0080 || bus.rf_we !== 1'b1 || bus.rf_wd3 !== 32'h77) begin
            fails++;
            $display("FAIL sb_wb: busy=%h we=%0b wd3=%h want 00000080/1/77", bus.busy_mask, bus.rf_we, bus.rf_wd3);
        end
        bus.lu_valid = 1'b1;
        bus.lu_rd    = 5'd7;
        bus.lu_data  = 32'h55;
        tick();
        drive_idle();
        tests++;
        if (bus.rf_we !== 1'b1 || bus.rf_a3 !== 5'd7 || bus.rf_wd3 !== 32'h55 || bus.busy_mask !== 32'd0) begin
            fails++;
            $display("FAIL sb_clear: we=%0b a3=%0d wd3=%h busy=%h want 1/7/55/0",
                     bus.rf_we, bus.rf_a3, bus.rf_wd3, bus.busy_mask);
        end
    endtask

    task automatic test_backpressure();
        int k;
        drive_idle();
        for (int i = 1; i <= 5; i++) begin
            bus.issue_valid = 1'b1;
            bus.issue_rd    = 5'(i);
            tick();
        end
        drive_idle();
        k = 0;
        for (int c = 0; c < 6; c++) begin
            bus.wb_valid = 1'b1;
            bus.wb_rd    = 5'(16 + c);
            bus.wb_data  = $urandom;
            bus.lu_valid = (k < 5);
            bus.lu_rd    = 5'(k + 1);
            bus.lu_data  = 32'h11 * (k + 1);
            if (c < 4 || c == 4) begin
                tests++;
                if (bus.lu_ready !== (c < 4)) begin
                    fails++;
                    $display("FAIL bp_ready c=%0d: got %0b want %0b", c, bus.lu_ready, (c < 4));
                end
            end
            if (bus.lu_valid && mq.size() < QD) k++;
            tick();
        end
        tests++;
        if (bus.q_count !== 3'd4 || bus.rf_a3 !== 5'd21) begin
            fails++;
            $display("FAIL bp_full: q=%0d a3=%0d want 4/21", bus.q_count, bus.rf_a3);
        end
        bus.wb_valid = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            bus.lu_valid = (k < 5);
            bus.lu_rd    = 5'(k + 1);
            bus.lu_data  = 32'h11 * (k + 1);
            if (bus.lu_valid && mq.size() < QD) k++;
            tick();
            tests++;
            if (bus.rf_we !== 1'b1 || bus.rf_a3 !== 5'(i) || bus.rf_wd3 !== 32'h11 * i) begin
                fails++;
                $display("FAIL bp_drain %0d: we=%0b a3=%0d wd3=%h want 1/%0d/%h",
                         i, bus.rf_we, bus.rf_a3, bus.rf_wd3, i, 32'h11 * i);
            end
        end
        drive_idle();
        tests++;
        if (bus.q_count !== 3'd0 || bus.busy_mask !== 32'd0) begin
            fails++;
            $display("FAIL bp_end: q=%0d busy=%h want 0/0", bus.q_count, bus.busy_mask);
        end
    endtask

    task automatic test_reset_mid_drain();
        drive_idle();
        for (int i = 10; i <= 13; i++) begin
            bus.issue_valid = 1'b1;
            bus.issue_rd    = 5'(i);
            tick();
        end
        drive_idle();
        for (int i = 10; i <= 13; i++) begin
            bus.wb_valid = 1'b1;
            bus.wb_rd    = 5'd20;
            bus.wb_data  = 32'(i);
            bus.lu_valid = 1'b1;
            bus.lu_rd    = 5'(i);
            bus.lu_data  = 32'hA00 + 32'(i);
            tick();
        end
        drive_idle();
        tick();
        tests++;
        if (bus.q_count !== 3'd3 || bus.rf_a3 !== 5'd10 || bus.busy_mask !== 32'h0000_3800) begin
            fails++;
            $display("FAIL rst_pre: q=%0d a3=%0d busy=%h want 3/10/00003800", bus.q_count, bus.rf_a3, bus.busy_mask);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if (bus.rf_we !== 1'b0 || bus.q_count !== 3'd0 || bus.busy_mask !== 32'd0) begin
            fails++;
            $display("FAIL rst_mid: we=%0b q=%0d busy=%h want 0/0/0", bus.rf_we, bus.q_count, bus.busy_mask);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if (bus.rf_we !== 1'b0 || bus.q_count !== 3'd0) begin
                fails++;
                $display("FAIL rst_stale %0d: we=%0b q=%0d want 0/0", i, bus.rf_we, bus.q_count);
            end
        end
    endtask

`ifdef WB_FWD_EN
    task automatic test_fwd();
        drive_idle();
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd9;
        bus.wb_data  = 32'hA5;
        tick();
        drive_idle();
        fwd_a1 = 5'd9;
        rf_rd1 = 32'h0;
        fwd_a2 = 5'd0;
        rf_rd2 = 32'h1234_5678;
        #1;
        tests++;
        if (op1 !== 32'hA5 || op2 !== 32'h1234_5678) begin
            fails++;
            $display("FAIL fwd_match: op1=%h op2=%h want a5/12345678", op1, op2);
        end
        tick();
        tests++;
        if (op1 !== 32'h0) begin
            fails++;
            $display("FAIL fwd_idle: op1=%h want 0", op1);
        end
    endtask
`endif

    task automatic test_random();
        logic [4:0]    pend[$];
        bit            hold;
        logic [4:0]    h_rd;
        logic [DW-1:0] h_data;
        logic [4:0]    r;
        hold   = 0;
        h_rd   = '0;
        h_data = '0;
        for (int c = 0; c < 800; c++) begin
            rst          = ($urandom_range(149) == 0);
            bus.wb_valid = ($urandom_range(1) == 1);
            bus.wb_rd    = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
            bus.wb_data  = $urandom;
            if (!hold) begin
                if (pend.size() > 0 && $urandom_range(2) != 0) begin
                    hold   = 1;
                    h_rd   = pend.pop_front();
                    h_data = $urandom;
                end else if ($urandom_range(15) == 0) begin
                    hold   = 1;
                    h_rd   = 5'd0;
                    h_data = $urandom;
                end
            end
            bus.lu_valid = hold;
            bus.lu_rd    = h_rd;
            bus.lu_data  = h_data;
            r = 5'($urandom_range(31));
            bus.issue_valid = ($urandom_range(1) == 1) && !exp_busy[r];
            bus.issue_rd    = r;
            tests++;
            if (bus.lu_ready !== (mq.size() < QD)) begin
                fails++;
                $display("FAIL rnd_ready c=%0d: got %0b want %0b", c, bus.lu_ready, (mq.size() < QD));
            end
            tick();
            tests++;
            if (bus.rf_we !== exp_we || bus.rf_a3 !== exp_a3 || bus.rf_wd3 !== exp_wd3 ||
                bus.busy_mask !== exp_busy || bus.q_count !== 3'(mq.size())) begin
                fails++;
                $display("FAIL rnd_out c=%0d: we=%0b a3=%0d wd3=%h busy=%h q=%0d want %0b/%0d/%h/%h/%0d",
                         c, bus.rf_we, bus.rf_a3, bus.rf_wd3, bus.busy_mask, bus.q_count,
                         exp_we, exp_a3, exp_wd3, exp_busy, mq.size());
            end
            if (rst) begin
                pend.delete();
                hold = 0;
            end else begin
                if (m_acc) hold = 0;
                if (bus.issue_valid && bus.issue_rd != 0) pend.push_back(bus.issue_rd);
            end
        end
        rst = 1'b0;
        drive_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_idle();
        test_reset();
        test_wb_basic();
        test_x0();
        test_scoreboard();
        test_backpressure();
        test_reset_mid_drain();
`ifdef WB_FWD_EN
        test_fwd();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback-side owner of the register file's single write port (write_enable/a3/wd3) in the decode stage.
- Merges two result sources:
  - the in-order pipeline writeback, which always wins;
  - a long-latency unit (divider / load-miss path), whose results are buffered in a small FIFO when they lose arbitration.
- Maintains a 32-bit busy scoreboard of registers awaiting long-latency results, for decode hazard stalls.

Parameters:
- DATA_WIDTH, 32, register/data width.
- QUEUE_DEPTH, 4, long-latency result FIFO entries; power of two, >=2.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- wb_valid  input  1  pipeline result valid this cycle; cannot be stalled
- wb_rd  input  5  pipeline destination register
- wb_data  input  DATA_WIDTH  pipeline result
- lu_valid  input  1  long-latency result offered
- lu_rd  input  5  long-latency destination register
- lu_data  input  DATA_WIDTH  long-latency result
- lu_ready  output  1  long-latency result accepted when lu_valid&&lu_ready
- issue_valid  input  1  decode dispatches an op to the long-latency unit
- issue_rd  input  5  destination of that op
- busy_mask  output  32  bit r set: register r awaits a long-latency result
- rf_we  output  1  to reg file write_enable
- rf_a3  output  5  to reg file a3
- rf_wd3  output  DATA_WIDTH  to reg file wd3
- q_count  output  $clog2(QUEUE_DEPTH)+1  current FIFO occupancy

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - Reset is synchronous and active-high on rst.
  - Reset has priority over every other event, including a reset arriving mid-drain; queued entries are discarded.
- Reset values:
  - rf_we=0, rf_a3=0, rf_wd3=0.
  - busy_mask=0, q_count=0.
  - FIFO pointers = 0.
  - lu_ready=1 the cycle after reset.
- Output timing:
  - rf_we, rf_a3 and rf_wd3 are registered.
  - A source selected in cycle N appears on rf_* in cycle N+1.
  - With no selection, rf_we=0 and rf_a3/rf_wd3 hold their previous values.
- x0 handling:
  - A wb or lu result with rd==0 is never written; rf_we stays 0.
  - An lu result with rd==0 is still accepted (consumed) so the unit never hangs.
  - issue_rd==0 never sets a busy bit; busy_mask[0] is constant 0.
- Per-cycle arbitration, highest priority first:
  - (1) wb_valid && wb_rd!=0 selects the pipeline.
  - (2) else FIFO non-empty: pop head and select it.
  - (3) else lu_valid && lu_rd!=0: bypass directly and do not enqueue.
  - (4) else no write.
- FIFO:
  - lu_ready = (q_count < QUEUE_DEPTH), combinational from registered count only.
  - An accepted lu result is enqueued unless it was bypassed in (3).
  - Full case: lu_ready=0 even if a pop happens the same cycle; no push-on-pop-when-full.
  - Simultaneous push and pop when not full: q_count unchanged.
  - Pointers wrap modulo QUEUE_DEPTH.
  - Order is strictly preserved.
- Scoreboard:
  - issue_valid && issue_rd!=0 sets busy[issue_rd] at the next edge.
  - A long-latency write clears busy[rd] on the edge where rf_we rises for it, i.e. the same edge that loads rf_*.
  - An lu result with rd==0 clears nothing.
  - Same-edge set and clear of the same register: set wins.
  - Pipeline writes never touch busy_mask.
  - Decode must not issue to a register that is already busy; in simulation the block asserts an $error if it does.
- Pipeline/long-latency conflict:
  - A pipeline write and a long-latency write to the same rd stay ordered by selection cycle.
  - The later write lands last.

Optional Feature:
- Macro: WB_FWD_EN.
- Defined: extra ports are added:
  - fwd_a1, fwd_a2  input  5
  - rf_rd1, rf_rd2  input  DATA_WIDTH
  - op1, op2  output  DATA_WIDTH
- Forwarding rule (combinational): opX = (rf_we && rf_a3==fwd_aX && fwd_aX!=0) ? rf_wd3 : rf_rdX.
  - This hides the write-pending cycle, during which the reg file still returns the old value.
- Undefined: those ports are absent, and decode stalls one extra cycle on a match.

Test Plan:
- Reset then wb_valid=1, wb_rd=5, wb_data=0xDEADBEEF for one cycle -> next cycle rf_we=1, rf_a3=5, rf_wd3=0xDEADBEEF; the cycle after, rf_we=0.
- wb_rd=0 with wb_valid=1, then lu result with lu_rd=0 -> rf_we never asserts; lu_ready stays 1; q_count stays 0.
- issue_rd=7; later lu_valid=1, lu_rd=7, lu_data=0x55 with idle pipeline -> busy_mask[7]=1 until the rf_we cycle writing 0x55 to x7, then 0.
- wb_valid held high 6 cycles while lu offers 5 results to x1..x5 (data 0x11..0x55):
  - lu_ready drops after the 4th result;
  - after wb goes idle, x1..x4 are written in order in consecutive cycles, then x5 is accepted and written.
- Reset asserted with q_count=3 mid-drain -> next cycle rf_we=0, q_count=0, busy_mask=0, and no stale entry is ever written.
- WB_FWD_EN defined: rf_we=1, rf_a3=9, rf_wd3=0xA5, fwd_a1=9, rf_rd1=0x00 -> op1=0xA5; with fwd_a2=0 -> op2=rf_rd2.
